// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: shared types and constants for the PE sequencer.
//   op_t      - vector command opcodes (5..7 are illegal)
//   state_t   - sequencer FSM states
//   pe_ctrl_t - every PE control field driven by the sequencer
//   CTRL_QUIET - control word presented whenever no result is being formed
package pe_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD      = 3'd0,
    OP_MUL      = 3'd1,
    OP_RELU6    = 3'd2,
    OP_MAC      = 3'd3,
    OP_MAC_RELU = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ELEM,
    ST_ACC_FIRST,
    ST_ACC_RUN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [1:0] add_a;
    logic [1:0] add_b;
    logic       c_acc;
    logic [1:0] sat8;
    logic       relu;
    logic [1:0] res;
    logic       comb;
    logic       enable_acc;
  } pe_ctrl_t;

  localparam pe_ctrl_t CTRL_QUIET = '{
    add_a:      2'd3,
    add_b:      2'd3,
    c_acc:      1'b0,
    sat8:       2'd3,
    relu:       1'b0,
    res:        2'd0,
    comb:       1'b0,
    enable_acc: 1'b0
  };

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic op_is_accum(input logic [2:0] op);
    return (op == OP_MAC) || (op == OP_MAC_RELU);
  endfunction

endpackage

// File: rtl/pe_ctrl_decode.sv
// pe_ctrl_decode: purely combinational (state, op) -> PE control word.
//   state - current sequencer state
//   op    - opcode of the command in flight
//   ctrl  - PE control word; enable_acc here means "accumulate on a consume"
//           and is qualified with the operand handshake by the caller.
module pe_ctrl_decode
  import pe_seq_pkg::*;
(
  input  state_t   state,
  input  op_t      op,
  output pe_ctrl_t ctrl
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ctrl = CTRL_QUIET;
    case (state)
      ST_ELEM: begin
        case (op)
          OP_ADD: begin
            ctrl.add_a = 2'd0;
            ctrl.add_b = 2'd0;
            ctrl.sat8  = 2'd2;
            ctrl.res   = 2'd2;
            ctrl.comb  = 1'b1;
          end
          OP_MUL: begin
            ctrl.sat8 = 2'd1;
            ctrl.res  = 2'd2;
            ctrl.comb = 1'b1;
          end
          OP_RELU6: begin
            ctrl.relu = 1'b0;
            ctrl.res  = 2'd3;
            ctrl.comb = 1'b1;
          end
          default: ctrl = CTRL_QUIET;
        endcase
      end
      // First element: acc <= A*B + 0.
      ST_ACC_FIRST: begin
        ctrl.add_a      = 2'd1;
        ctrl.add_b      = 2'd3;
        ctrl.enable_acc = 1'b1;
      end
      // Later elements: acc <= A*B + acc.
      ST_ACC_RUN: begin
        ctrl.add_a      = 2'd1;
        ctrl.add_b      = 2'd1;
        ctrl.c_acc      = 1'b1;
        ctrl.enable_acc = 1'b1;
      end
      ST_DRAIN: begin
        ctrl.c_acc = 1'b1;
        ctrl.sat8  = 2'd0;
        ctrl.comb  = 1'b1;
        if (op == OP_MAC_RELU) begin
          ctrl.relu = 1'b1;
          ctrl.res  = 2'd3;
        end else begin
          ctrl.res  = 2'd2;
        end
      end
      default: ctrl = CTRL_QUIET;
    endcase
  end

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: command-driven controller for one processing-element lane.
//   clk, reset          - single clock, asynchronous active-high reset
//   cmd_valid/ready     - command handshake (ready only in IDLE)
//   cmd_op, cmd_len     - opcode and element count minus 1
//   opnd_valid/ready    - operand-set handshake; ready = consumed this edge
//   res_valid/last/ready- result handshake for PE output r
//   err_illegal         - one-cycle pulse after an illegal opcode is accepted
//   mux_*, enable_acc   - PE control word
// Operand data never passes through this block.
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             opnd_valid,
  output logic             opnd_ready,
  output logic             res_valid,
  output logic             res_last,
  input  logic             res_ready,
  output logic             err_illegal,
  output logic [1:0]       mux_add_a,
  output logic [1:0]       mux_add_b,
  output logic             mux_c_acc,
  output logic [1:0]       mux_sat8,
  output logic             mux_relu,
  output logic [1:0]       mux_res,
  output logic             mux_comb,
  output logic             enable_acc
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_illegal_q, err_illegal_d;

  pe_ctrl_t dec_ctrl;
  pe_ctrl_t ctrl;
  logic     consume;
  logic     cnt_zero;

  pe_ctrl_decode u_decode (
    .state (state_q),
    .op    (op_q),
    .ctrl  (dec_ctrl)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    err_illegal_d = 1'b0;
    cmd_ready     = 1'b0;
    opnd_ready    = 1'b0;
    res_valid     = 1'b0;
    res_last      = 1'b0;
    consume       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_d = cmd_len;
          op_d  = op_t'(cmd_op);
          if (!op_is_legal(cmd_op)) begin
            err_illegal_d = 1'b1;
          end else if (op_is_accum(cmd_op)) begin
            state_d = ST_ACC_FIRST;
          end else begin
            state_d = ST_ELEM;
          end
        end
      end

      // Result is combinational from the operands, so an element is only
      // consumed when downstream takes the result in the same cycle.
      ST_ELEM: begin
        res_valid  = opnd_valid;
        res_last   = cnt_zero;
        consume    = opnd_valid & res_ready;
        opnd_ready = consume;
        if (consume) begin
          if (cnt_zero) state_d = ST_IDLE;
          else          cnt_d   = cnt_q - 1'b1;
        end
      end

      ST_ACC_FIRST, ST_ACC_RUN: begin
        consume    = opnd_valid;
        opnd_ready = consume;
        if (consume) begin
          if (cnt_zero) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = ST_ACC_RUN;
          end
        end
      end

      ST_DRAIN: begin
        res_valid = 1'b1;
        res_last  = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // An elementwise slot with no operand presents no result, so it goes QUIET;
  // accumulation only happens on an actual operand consume.
  always_comb begin
    ctrl = dec_ctrl;
    if (state_q == ST_ELEM && !opnd_valid) ctrl = CTRL_QUIET;
    ctrl.enable_acc = dec_ctrl.enable_acc & consume;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ADD;
      cnt_q         <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign err_illegal = err_illegal_q;
  assign mux_add_a   = ctrl.add_a;
  assign mux_add_b   = ctrl.add_b;
  assign mux_c_acc   = ctrl.c_acc;
  assign mux_sat8    = ctrl.sat8;
  assign mux_relu    = ctrl.relu;
  assign mux_res     = ctrl.res;
  assign mux_comb    = ctrl.comb;
  assign enable_acc  = ctrl.enable_acc;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: self-checking bench for pe_sequencer. A command-level
// reference model (elements left, accumulate phase, draining) predicts every
// output each cycle; directed sequences cover the notable cases and a
// randomized run covers the rest.
module tb_pe_sequencer;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             opnd_valid;
  logic             opnd_ready;
  logic             res_valid;
  logic             res_last;
  logic             res_ready;
  logic             err_illegal;
  logic [1:0]       mux_add_a;
  logic [1:0]       mux_add_b;
  logic             mux_c_acc;
  logic [1:0]       mux_sat8;
  logic             mux_relu;
  logic [1:0]       mux_res;
  logic             mux_comb;
  logic             enable_acc;

  pe_sequencer #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .opnd_valid  (opnd_valid),
    .opnd_ready  (opnd_ready),
    .res_valid   (res_valid),
    .res_last    (res_last),
    .res_ready   (res_ready),
    .err_illegal (err_illegal),
    .mux_add_a   (mux_add_a),
    .mux_add_b   (mux_add_b),
    .mux_c_acc   (mux_c_acc),
    .mux_sat8    (mux_sat8),
    .mux_relu    (mux_relu),
    .mux_res     (mux_res),
    .mux_comb    (mux_comb),
    .enable_acc  (enable_acc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control word packed as {add_a, add_b, c_acc, sat8, relu, res, comb, enable_acc}.
  function automatic logic [11:0] cw(input logic [1:0] aa, input logic [1:0] ab,
                                     input logic ca, input logic [1:0] s8,
                                     input logic rl, input logic [1:0] rs,
                                     input logic cb, input logic en);
    return {aa, ab, ca, s8, rl, rs, cb, en};
  endfunction

  // ---------------- reference model ----------------
  bit busy;
  int m_op;
  int left;       // operand sets still to be consumed
  bit first;      // next accumulate element starts a fresh sum
  bit draining;   // accumulate finished, result on offer
  bit err_pend;

  task automatic model_reset();
    busy = 0; m_op = 0; left = 0; first = 0; draining = 0; err_pend = 0;
  endtask

  task automatic check_outputs(input bit ov, input bit rr);
    logic        e_cr, e_or, e_rv, e_rl;
    logic [11:0] e_cw;
    logic [11:0] quiet;
    quiet = cw(2'd3, 2'd3, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    e_cr = !busy; e_or = 0; e_rv = 0; e_rl = 0; e_cw = quiet;
    if (busy && m_op <= 2) begin
      e_rv = ov;
      e_rl = (left == 1);
      e_or = ov & rr;
      if (ov) begin
        case (m_op)
          0: e_cw = cw(2'd0, 2'd0, 1'b0, 2'd2, 1'b0, 2'd2, 1'b1, 1'b0);
          1: e_cw = cw(2'd3, 2'd3, 1'b0, 2'd1, 1'b0, 2'd2, 1'b1, 1'b0);
          default: e_cw = cw(2'd3, 2'd3, 1'b0, 2'd3, 1'b0, 2'd3, 1'b1, 1'b0);
        endcase
      end
    end else if (busy && draining) begin
      e_rv = 1; e_rl = 1;
      if (m_op == 4) e_cw = cw(2'd3, 2'd3, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0);
      else           e_cw = cw(2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    end else if (busy) begin
      e_or = ov;
      if (first) e_cw = cw(2'd1, 2'd3, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, ov);
      else       e_cw = cw(2'd1, 2'd1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, ov);
    end
    check("cmd_ready",   32'(cmd_ready),   32'(e_cr));
    check("opnd_ready",  32'(opnd_ready),  32'(e_or));
    check("res_valid",   32'(res_valid),   32'(e_rv));
    check("res_last",    32'(res_last),    32'(e_rl));
    check("err_illegal", 32'(err_illegal), 32'(err_pend));
    check("ctrl_word",
          32'({mux_add_a, mux_add_b, mux_c_acc, mux_sat8, mux_relu, mux_res, mux_comb, enable_acc}),
          32'(e_cw));
  endtask

  task automatic model_advance(input bit cv, input int op, input int len, input bit ov, input bit rr);
    err_pend = !busy && cv && (op > 4);
    if (!busy) begin
      if (cv && op <= 4) begin
        busy = 1; m_op = op; left = len + 1; first = 1; draining = 0;
      end
    end else if (m_op <= 2) begin
      if (ov && rr) begin
        left--;
        if (left == 0) busy = 0;
      end
    end else if (draining) begin
      if (rr) busy = 0;
    end else if (ov) begin
      first = 0;
      left--;
      if (left == 0) draining = 1;
    end
  endtask

  // One clock: drive just after the rising edge, check on the falling edge.
  task automatic step(input bit cv, input int op, input int len, input bit ov, input bit rr);
    cmd_valid  = cv;
    cmd_op     = 3'(op);
    cmd_len    = LEN_W'(len);
    opnd_valid = ov;
    res_ready  = rr;
    @(negedge clk);
    check_outputs(ov, rr);
    model_advance(cv, op, len, ov, rr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 0; cmd_op = '0; cmd_len = '0; opnd_valid = 0; res_ready = 0;
    model_reset();
    #1;
    check_outputs(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MUL, one element: result and last in the same cycle, then idle.
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // MAC and MAC_RELU over three operand sets, with a drain stall.
    step(1, 3, 2, 0, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 4, 2, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // ADD of 4 with res_ready low for 3 cycles on element 2.
    step(1, 0, 3, 0, 1);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // RELU6 of 2 with an operand gap.
    step(1, 2, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1, 1);

    // Illegal opcode: single err pulse, no result, still ready.
    step(1, 6, 2, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Longest command: 2^LEN_W elements, no wrap.
    step(1, 0, 255, 0, 1);
    repeat (256) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Reset in ACC_RUN with 6 sets still to go.
    step(1, 3, 6, 0, 1);
    step(0, 0, 0, 1, 1);
    opnd_valid = 1'b1;
    res_ready  = 1'b1;
    #1;
    check_outputs(1'b1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 3) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
           ($urandom % 4) != 0, ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
